bcd_to_binary_converter: RTL and testbench

//   Converts a packed multi-digit BCD value to unsigned binary, most significant digit first,

---
 rtl/bcd_to_binary_converter_if.sv | 14 +
 rtl/bcd_to_binary_converter.sv | 64 ++++++
 tb/tb_bcd_to_binary_converter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_converter_if.sv
// bcd_to_binary_converter_if: start/busy/done request bus for the BCD-to-binary converter
interface bcd_to_binary_converter_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  error;
  modport master (output start, bcd_in, input busy, done, bin_out, error);
  modport slave  (input start, bcd_in, output busy, done, bin_out, error);
endinterface

// File: rtl/bcd_to_binary_converter.sv
// bcd_to_binary_converter: MSD-first packed BCD to binary, one multiply-accumulate step per digit
module bcd_to_binary_converter #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  bcd_to_binary_converter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  localparam logic [3:0] NDIG = 4'(DIGITS);
  state_t              state, state_nxt;
  logic [4*DIGITS-1:0] shreg;
  logic [BIN_W+3:0]    acc, acc_step;
  logic [3:0]          cnt;
  logic                bad;
  logic                accept;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) bad = bad | (bus.bcd_in[4*i +: 4] > 4'd9);
  end
  // acc*10 as shift-add keeps the step a pair of adders
  assign acc_step = (acc << 3) + (acc << 1) + {{BIN_W{1'b0}}, shreg[4*DIGITS-1 -: 4]};
  assign accept   = (state == IDLE) && bus.start;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? (bad ? DONE : CONV) : IDLE;
      CONV:    state_nxt = (cnt == 4'd1) ? DONE : CONV;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      acc         <= '0;
      cnt         <= '0;
      bus.bin_out <= '0;
      bus.error   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept && bad) begin
        bus.bin_out <= '0;
        bus.error   <= 1'b1;
      end else if (accept) begin
        shreg <= bus.bcd_in;
        acc   <= '0;
        cnt   <= NDIG;
      end else if (state == CONV) begin
        acc   <= acc_step;
        shreg <= shreg << 4;
        cnt   <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          bus.bin_out <= acc_step[BIN_W-1:0];
          bus.error   <= 1'b0;
        end
      end
    end
  end
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_bcd_to_binary_converter.sv
// tb_bcd_to_binary_converter: directed checks of the 4-digit converter plus a 2-digit build
module tb_bcd_to_binary_converter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bcd_to_binary_converter_if #(.DIGITS(4), .BIN_W(14)) bus ();
  bcd_to_binary_converter_if #(.DIGITS(2), .BIN_W(7))  sbus ();
  bcd_to_binary_converter #(.DIGITS(4), .BIN_W(14)) dut (.clk(clk), .reset(reset), .bus(bus));
  bcd_to_binary_converter #(.DIGITS(2), .BIN_W(7))  sdut (.clk(clk), .reset(reset), .bus(sbus));
  always #5 clk = ~clk;

  task automatic run(input logic [15:0] v, output int dc, output int bc,
                     output logic [13:0] b, output logic e);
    bus.bcd_in = v;
    bus.start  = 1'b1;
    dc = -1; bc = 0; b = 'x; e = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) bc++;
      if (bus.done) begin dc = c; b = bus.bin_out; e = bus.error; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0; bus.bcd_in = '0; sbus.start = 1'b0; sbus.bcd_in = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.bin_out !== 14'd0) begin errors++; $display("FAIL reset_bin got %0d want 0", bus.bin_out); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", bus.error); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_valid;
    logic [15:0] vin [3] = '{16'h1234, 16'h9999, 16'h0000};
    logic [13:0] exp [3] = '{14'd1234, 14'd9999, 14'd0};
    int dc, bc; logic [13:0] b; logic e;
    for (int i = 0; i < 3; i++) begin
      run(vin[i], dc, bc, b, e);
      checks++; if (dc != 5) begin errors++; $display("FAIL valid_done_cycle[%0d] got %0d want 5", i, dc); end
      checks++; if (bc != 5) begin errors++; $display("FAIL valid_busy_cycles[%0d] got %0d want 5", i, bc); end
      checks++; if (b !== exp[i]) begin errors++; $display("FAIL valid_bin[%0d] got %0d want %0d", i, b, exp[i]); end
      checks++; if (e !== 1'b0) begin errors++; $display("FAIL valid_error[%0d] got %b want 0", i, e); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL valid_idle_after[%0d] busy got %b want 0", i, bus.busy); end
    end
  endtask

  task automatic test_invalid;
    int dc, bc; logic [13:0] b; logic e;
    run(16'h0007, dc, bc, b, e);
    run(16'h12A4, dc, bc, b, e);
    checks++; if (dc != 1) begin errors++; $display("FAIL invalid_done_cycle got %0d want 1", dc); end
    checks++; if (bc != 1) begin errors++; $display("FAIL invalid_busy_cycles got %0d want 1", bc); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL invalid_error got %b want 1", e); end
    checks++; if (b !== 14'd0) begin errors++; $display("FAIL invalid_bin got %0d want 0", b); end
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL invalid_error_held got %b want 1", bus.error); end
    run(16'h0001, dc, bc, b, e);
    checks++; if (e !== 1'b0 || b !== 14'd1) begin errors++; $display("FAIL invalid_then_valid got err=%b bin=%0d want err=0 bin=1", e, b); end
  endtask

  task automatic test_ignore;
    int dc = -1; int extra = 0;
    bus.bcd_in = 16'h0042; bus.start = 1'b1;
    for (int c = 1; c <= 20 && dc < 0; c++) begin
      @(negedge clk);
      bus.start = (c == 2);
      if (c == 2) bus.bcd_in = 16'h0777;
      if (bus.done) dc = c;
    end
    checks++; if (dc != 5) begin errors++; $display("FAIL ignore_done_cycle got %0d want 5", dc); end
    checks++; if (bus.bin_out !== 14'd42) begin errors++; $display("FAIL ignore_bin got %0d want 42", bus.bin_out); end
    for (int c = 0; c < 8; c++) begin @(negedge clk); if (bus.done || bus.busy) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL ignore_not_queued got %0d busy/done cycles want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int d1 = -1; int d2 = -1;
    bus.bcd_in = 16'h0012; bus.start = 1'b1;
    for (int c = 1; c <= 30 && d2 < 0; c++) begin
      @(negedge clk);
      if (bus.done && d1 < 0) d1 = c;
      else if (bus.done) d2 = c;
    end
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (d1 != 5) begin errors++; $display("FAIL b2b_first_done got %0d want 5", d1); end
    checks++; if (d2 != 11) begin errors++; $display("FAIL b2b_second_done got %0d want 11", d2); end
    checks++; if (bus.bin_out !== 14'd12 || bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_final got bin=%0d busy=%b want bin=12 busy=0", bus.bin_out, bus.busy); end
  endtask

  task automatic test_bcd_change;
    int dc = -1;
    bus.bcd_in = 16'h0815; bus.start = 1'b1;
    for (int c = 1; c <= 20 && dc < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.bcd_in = 16'($urandom);
      if (bus.done) dc = c;
    end
    checks++; if (dc != 5) begin errors++; $display("FAIL change_done_cycle got %0d want 5", dc); end
    checks++; if (bus.bin_out !== 14'd815 || bus.error !== 1'b0) begin errors++; $display("FAIL change_bin got %0d err=%b want 815 err=0", bus.bin_out, bus.error); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int late = 0;
    bus.bcd_in = 16'h5678; bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    checks++; if (bus.bin_out !== 14'd0 || bus.error !== 1'b0) begin errors++; $display("FAIL midreset_data got bin=%0d err=%b want 0 0", bus.bin_out, bus.error); end
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); if (bus.done || bus.busy) late++; end
    checks++; if (late != 0) begin errors++; $display("FAIL midreset_no_done got %0d busy/done cycles want 0", late); end
  endtask

  task automatic test_small;
    int dc = -1;
    sbus.bcd_in = 8'h99; sbus.start = 1'b1;
    for (int c = 1; c <= 10 && dc < 0; c++) begin
      @(negedge clk);
      sbus.start = 1'b0;
      if (sbus.done) dc = c;
    end
    checks++; if (dc != 3) begin errors++; $display("FAIL small_done_cycle got %0d want 3", dc); end
    checks++; if (sbus.bin_out !== 7'd99 || sbus.error !== 1'b0) begin errors++; $display("FAIL small_bin got %0d err=%b want 99 err=0", sbus.bin_out, sbus.error); end
    @(negedge clk);
    dc = -1;
    sbus.bcd_in = 8'hB3; sbus.start = 1'b1;
    for (int c = 1; c <= 10 && dc < 0; c++) begin
      @(negedge clk);
      sbus.start = 1'b0;
      if (sbus.done) dc = c;
    end
    checks++; if (dc != 1 || sbus.error !== 1'b1 || sbus.bin_out !== 7'd0) begin errors++; $display("FAIL small_invalid got cyc=%0d err=%b bin=%0d want 1 1 0", dc, sbus.error, sbus.bin_out); end
  endtask

  initial begin
    test_reset;
    test_valid;
    test_invalid;
    test_ignore;
    test_back_to_back;
    test_bcd_change;
    test_reset_mid;
    test_small;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
